l2_control: RTL and testbench
=============================

L2_CONTROL -- requirements
Module: l2_control

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk (rising edge) and rst_n (asynchronous, active low).
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-003 SHALL have ports: l2_read  in  1  read request; l2_write  in  1  write request; l2_address  in  16  byte address; l2_wdata  in  128  line to write; l2_rdata  out  128  line read; l2_resp  out  1  request done.
REQ-004 SHALL have ports: pmem_read  out  1; pmem_write  out  1; pmem_address  out  16  line-aligned; pmem_wdata  out  128; pmem_rdata  in  128; pmem_resp  in  1.
REQ-005 SHALL have ports: way_index  out  3  set index to both ways; way_load_d / way_load_v / way_load_td  out  2  per-way write strobes (bit i = way i); way_d_in / way_v_in  out  1; way_tag_in  out  9; way_data_in  out  128.
REQ-006 SHALL have ports: way_d_out / way_v_out  in  2  per-way; way_tag_out  in  2x9; way_data_out  in  2x128; way arrays read combinationally and write on clk when strobed.

Function
REQ-007 SHALL split address as tag=[15:7], index=[6:4], offset=[3:0]; offset is ignored and pmem_address low 4 bits are always 0.
REQ-008 SHALL implement states INIT, IDLE, WRITEBACK, ALLOCATE.
REQ-009 INIT: 3-bit counter drives way_index; assert way_load_v=2'b11 and way_load_d=2'b11 with v_in=0 and d_in=0 for 8 cycles (indexes 0..7); go to IDLE after index 7; l2_resp=0 throughout.
REQ-010 IDLE: way_index=l2_address[6:4]; hit(i) = way_v_out[i] AND way_tag_out[i]==tag; at most one way is valid for a tag.
REQ-011 IDLE read hit: l2_resp=1 and l2_rdata=hit way data in the same cycle; the LRU bit for the index is set to the other way at the clock edge.
REQ-012 IDLE write hit: same cycle, strobe load_td, load_d and load_v for the hit way; data_in=l2_wdata, tag_in=tag, d_in=1, v_in=1; l2_resp=1; LRU is updated as in REQ-011.
REQ-013 IDLE miss: victim = LRU[index]; go to WRITEBACK if victim is valid and dirty, else go to ALLOCATE; l2_resp=0.
REQ-014 WRITEBACK: pmem_write=1, pmem_address={victim tag,index,4'h0}, pmem_wdata=victim data; hold until pmem_resp=1, then go to ALLOCATE.
REQ-015 ALLOCATE: pmem_read=1, pmem_address={tag,index,4'h0}; on pmem_resp=1, strobe load_td, load_v and load_d for the victim with data_in=pmem_rdata, v_in=1, d_in=0; then go to IDLE.
REQ-016 After ALLOCATE, IDLE SHALL service the held request as a hit; clean-miss latency = memory latency + 1 cycle; dirty miss adds the writeback latency.
REQ-017 pmem_read and pmem_write SHALL never be asserted together; both are 0 in INIT and IDLE.
REQ-018 Requester SHALL hold l2_read/l2_write, l2_address and l2_wdata stable until l2_resp; l2_read and l2_write asserted together is illegal, and the block is not required to handle it.
REQ-019 No request in IDLE: no strobes, l2_resp=0, LRU unchanged.
REQ-020 The LRU array is 8x1 inside the block; victim choice uses the registered LRU value at the miss.
REQ-021 Outputs SHALL be combinational from state and inputs; only state, INIT counter and LRU are registered.

Reset
REQ-022 rst_n=0 SHALL immediately force state=INIT, counter=0, LRU=all 0; pmem_read, pmem_write and l2_resp go to 0 without waiting for clk.
REQ-023 Reset during WRITEBACK or ALLOCATE SHALL abandon the transfer; the INIT sweep invalidates all lines afterward.
REQ-024 l2_rdata SHALL be don't-care when l2_resp=0.

Verification
REQ-025 Release reset -> 8 cycles of way_load_v=2'b11 with way_index 0..7 and v_in=0, then IDLE; an l2_read held during INIT gets no resp until INIT completes.
REQ-026 Read 0x1230 after INIT -> ALLOCATE with pmem_address=0x1230; pmem_resp with rdata=0xA5..A5 -> way0 filled; next cycle l2_resp=1 with l2_rdata=0xA5..A5 and LRU[3]=1.
REQ-027 Write 0x1234 (hit) with data D -> same-cycle l2_resp; way0 d=1; read 0x1230 -> returns D.
REQ-028 Fill way1 at index 3 with tag 0x0AB, then touch way0 and miss on tag 0x0CD -> victim way1 chosen; if way1 is dirty, WRITEBACK precedes ALLOCATE with pmem_address={0x0AB,3,0}.
REQ-029 Assert rst_n=0 mid-WRITEBACK -> pmem_write drops asynchronously; INIT reruns; a subsequent read misses.
REQ-030 Dirty-miss sequence with 3-cycle pmem latency -> pmem_write and pmem_read never overlap, and l2_resp is asserted exactly once.

Source files
------------

// File: rtl/l2_control.sv
// rtl/l2_control.sv - two-way L2 cache controller with INIT sweep, writeback and allocate
module l2_control (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               l2_read,
    input  logic               l2_write,
    input  logic [15:0]        l2_address,
    input  logic [127:0]       l2_wdata,
    output logic [127:0]       l2_rdata,
    output logic               l2_resp,

    output logic               pmem_read,
    output logic               pmem_write,
    output logic [15:0]        pmem_address,
    output logic [127:0]       pmem_wdata,
    input  logic [127:0]       pmem_rdata,
    input  logic               pmem_resp,

    output logic [2:0]         way_index,
    output logic [1:0]         way_load_d,
    output logic [1:0]         way_load_v,
    output logic [1:0]         way_load_td,
    output logic               way_d_in,
    output logic               way_v_in,
    output logic [8:0]         way_tag_in,
    output logic [127:0]       way_data_in,

    input  logic [1:0]         way_d_out,
    input  logic [1:0]         way_v_out,
    input  logic [1:0][8:0]    way_tag_out,
    input  logic [1:0][127:0]  way_data_out
);

    typedef enum logic [1:0] {
        S_INIT      = 2'd0,
        S_IDLE      = 2'd1,
        S_WRITEBACK = 2'd2,
        S_ALLOCATE  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] lru_q, lru_d;

    logic [8:0] req_tag;
    logic [2:0] req_index;
    logic       req_any;
    logic [1:0] hit;
    logic       any_hit;
    logic       hit_way;
    logic       victim;
    logic [1:0] victim_mask;
    logic       victim_dirty;
    logic       unused_offset;

    // Byte offset never matters: whole lines move in every transfer.
    assign unused_offset = ^l2_address[3:0];

    assign req_tag      = l2_address[15:7];
    assign req_index    = l2_address[6:4];
    assign req_any      = l2_read | l2_write;

    assign hit[0]       = way_v_out[0] & (way_tag_out[0] == req_tag);
    assign hit[1]       = way_v_out[1] & (way_tag_out[1] == req_tag);
    assign any_hit      = |hit;
    assign hit_way      = hit[1];

    // The LRU bit names the way to evict; it only changes on hits, so it is
    // stable for the whole miss sequence of the held request.
    assign victim       = lru_q[req_index];
    assign victim_mask  = victim ? 2'b10 : 2'b01;
    assign victim_dirty = way_v_out[victim] & way_d_out[victim];

    // Next-state, LRU update and all combinational outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lru_d        = lru_q;

        l2_resp      = 1'b0;
        l2_rdata     = way_data_out[hit_way];

        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {req_tag, req_index, 4'h0};
        pmem_wdata   = way_data_out[victim];

        way_index    = req_index;
        way_load_d   = 2'b00;
        way_load_v   = 2'b00;
        way_load_td  = 2'b00;
        way_d_in     = 1'b0;
        way_v_in     = 1'b0;
        way_tag_in   = req_tag;
        way_data_in  = l2_wdata;

        case (state_q)
            S_INIT: begin
                // Sweep every set, clearing valid and dirty in both ways.
                way_index  = cnt_q;
                way_load_v = 2'b11;
                way_load_d = 2'b11;
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (req_any) begin
                    if (any_hit) begin
                        l2_resp            = 1'b1;
                        lru_d[req_index]   = ~hit_way;
                        if (l2_write) begin
                            way_load_td = hit;
                            way_load_d  = hit;
                            way_load_v  = hit;
                            way_d_in    = 1'b1;
                            way_v_in    = 1'b1;
                        end
                    end else if (victim_dirty) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
            end

            S_WRITEBACK: begin
                // Evicted line goes back to the address its own tag names.
                pmem_write   = 1'b1;
                pmem_address = {way_tag_out[victim], req_index, 4'h0};
                if (pmem_resp) begin
                    state_d = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    way_load_td = victim_mask;
                    way_load_v  = victim_mask;
                    way_load_d  = victim_mask;
                    way_data_in = pmem_rdata;
                    way_v_in    = 1'b1;
                    way_d_in    = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State, INIT counter and LRU bits; reset restarts the INIT sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= 3'd0;
            lru_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lru_q   <= lru_d;
        end
    end

endmodule

// File: tb/tb_l2_control.sv
// tb/tb_l2_control.sv - directed self-checking bench for l2_control with behavioural way arrays
module tb_l2_control;

    logic               clk;
    logic               rst_n;
    logic               l2_read;
    logic               l2_write;
    logic [15:0]        l2_address;
    logic [127:0]       l2_wdata;
    logic [127:0]       l2_rdata;
    logic               l2_resp;
    logic               pmem_read;
    logic               pmem_write;
    logic [15:0]        pmem_address;
    logic [127:0]       pmem_wdata;
    logic [127:0]       pmem_rdata;
    logic               pmem_resp;
    logic [2:0]         way_index;
    logic [1:0]         way_load_d;
    logic [1:0]         way_load_v;
    logic [1:0]         way_load_td;
    logic               way_d_in;
    logic               way_v_in;
    logic [8:0]         way_tag_in;
    logic [127:0]       way_data_in;
    logic [1:0]         way_d_out;
    logic [1:0]         way_v_out;
    logic [1:0][8:0]    way_tag_out;
    logic [1:0][127:0]  way_data_out;

    int total = 0;
    int bad   = 0;
    int resp_cnt = 0;
    int resp_base;
    logic overlap = 1'b0;

    localparam logic [127:0] DAT_A5 = {16{8'ha5}};
    localparam logic [127:0] DAT_D  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] DAT_R1 = {8{16'h1111}};
    localparam logic [127:0] DAT_W1 = {4{32'hdeadbeef}};
    localparam logic [127:0] DAT_R2 = {8{16'h2222}};

    logic         v_m   [2][8];
    logic         d_m   [2][8];
    logic [8:0]   t_m   [2][8];
    logic [127:0] dat_m [2][8];

    l2_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_rdata     (l2_rdata),
        .l2_resp      (l2_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .way_index    (way_index),
        .way_load_d   (way_load_d),
        .way_load_v   (way_load_v),
        .way_load_td  (way_load_td),
        .way_d_in     (way_d_in),
        .way_v_in     (way_v_in),
        .way_tag_in   (way_tag_in),
        .way_data_in  (way_data_in),
        .way_d_out    (way_d_out),
        .way_v_out    (way_v_out),
        .way_tag_out  (way_tag_out),
        .way_data_out (way_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up garbage: every line looks valid, dirty and tagged for 0x1230.
    initial begin
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < 8; s++) begin
                v_m[w][s]   = 1'b1;
                d_m[w][s]   = 1'b1;
                t_m[w][s]   = 9'h024;
                dat_m[w][s] = 128'h0;
            end
        end
    end

    // Way arrays: combinational read at way_index.
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_v_out[w]    = v_m[w][way_index];
            way_d_out[w]    = d_m[w][way_index];
            way_tag_out[w]  = t_m[w][way_index];
            way_data_out[w] = dat_m[w][way_index];
        end
    end

    // Way arrays: strobed write on the clock.
    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (way_load_v[w])  v_m[w][way_index]   <= way_v_in;
            if (way_load_d[w])  d_m[w][way_index]   <= way_d_in;
            if (way_load_td[w]) begin
                t_m[w][way_index]   <= way_tag_in;
                dat_m[w][way_index] <= way_data_in;
            end
        end
    end

    // Response counter and memory-port overlap monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (l2_resp) resp_cnt <= resp_cnt + 1;
        if (pmem_read && pmem_write) overlap <= 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        l2_read    = 1'b1;
        l2_write   = 1'b0;
        l2_address = 16'h1230;
        l2_wdata   = 128'h0;
        pmem_resp  = 1'b0;
        pmem_rdata = 128'h0;

        // Reset state
        #3;
        chk("rst_resp",   l2_resp,    0);
        chk("rst_pread",  pmem_read,  0);
        chk("rst_pwrite", pmem_write, 0);
        chk("rst_loadv",  way_load_v, 2'b11);
        chk("rst_index",  way_index,  0);

        @(posedge clk);
        next_cycle();
        rst_n = 1'b1;

        // INIT sweep with a read held the whole time
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("init_index", way_index,  i);
            chk("init_loadv", way_load_v, 2'b11);
            chk("init_loadd", way_load_d, 2'b11);
            chk("init_vin",   way_v_in,   0);
            chk("init_din",   way_d_in,   0);
            chk("init_resp",  l2_resp,    0);
            next_cycle();
        end

        // IDLE: read 0x1230 misses on a freshly swept cache
        #1;
        chk("idle_miss_resp",  l2_resp,   0);
        chk("idle_index",      way_index, 3);
        chk("idle_pread",      pmem_read, 0);
        chk("swept_v0",        v_m[0][3], 0);
        chk("swept_v1",        v_m[1][7], 0);

        next_cycle(); #1;
        chk("alloc1_pread",  pmem_read,    1);
        chk("alloc1_pwrite", pmem_write,   0);
        chk("alloc1_paddr",  pmem_address, 16'h1230);
        chk("alloc1_resp",   l2_resp,      0);
        next_cycle(); #1;
        chk("alloc1_hold",   pmem_read,    1);
        pmem_resp  = 1'b1;
        pmem_rdata = DAT_A5;
        #1;
        chk("alloc1_loadv",  way_load_v,  2'b01);
        chk("alloc1_loadtd", way_load_td, 2'b01);
        chk("alloc1_vin",    way_v_in,    1);
        chk("alloc1_din",    way_d_in,    0);
        chk("alloc1_tagin",  way_tag_in,  9'h024);

        next_cycle();
        pmem_resp = 1'b0;
        #1;
        chk("hit1_resp",  l2_resp,    1);
        chk("hit1_rdata", l2_rdata,   DAT_A5);
        chk("hit1_loadv", way_load_v, 2'b00);

        next_cycle();
        l2_read = 1'b0;
        #1;
        chk("noreq_resp",   l2_resp,     0);
        chk("noreq_loadtd", way_load_td, 2'b00);
        chk("noreq_loadv",  way_load_v,  2'b00);

        // Write hit 0x1234, then read back through 0x1230
        l2_write   = 1'b1;
        l2_address = 16'h1234;
        l2_wdata   = DAT_D;
        #1;
        chk("whit_resp",   l2_resp,     1);
        chk("whit_loadtd", way_load_td, 2'b01);
        chk("whit_loadd",  way_load_d,  2'b01);
        chk("whit_din",    way_d_in,    1);
        chk("whit_data",   way_data_in, DAT_D);

        next_cycle();
        chk("whit_dirty", d_m[0][3], 1);
        l2_write   = 1'b0;
        l2_read    = 1'b1;
        l2_address = 16'h1230;
        #1;
        chk("rback_resp",  l2_resp,  1);
        chk("rback_rdata", l2_rdata, DAT_D);

        // Fill way1 at index 3 with tag 0x0AB
        next_cycle();
        l2_address = 16'h55b0;
        #1;
        chk("fill1_miss", l2_resp,    0);
        chk("fill1_nowb", pmem_write, 0);
        next_cycle(); #1;
        chk("fill1_pread", pmem_read,    1);
        chk("fill1_paddr", pmem_address, 16'h55b0);
        pmem_resp  = 1'b1;
        pmem_rdata = DAT_R1;
        #1;
        chk("fill1_loadv", way_load_v, 2'b10);
        next_cycle();
        pmem_resp = 1'b0;
        #1;
        chk("fill1_resp",  l2_resp,  1);
        chk("fill1_rdata", l2_rdata, DAT_R1);

        // Dirty way1, then touch way0
        next_cycle();
        l2_read  = 1'b0;
        l2_write = 1'b1;
        l2_wdata = DAT_W1;
        #1;
        chk("w1_resp",  l2_resp,    1);
        chk("w1_loadd", way_load_d, 2'b10);
        next_cycle();
        l2_write   = 1'b0;
        l2_read    = 1'b1;
        l2_address = 16'h1230;
        #1;
        chk("touch0_rdata", l2_rdata, DAT_D);

        // Miss on tag 0x0CD: dirty way1 is the victim, 3-cycle memory latency
        next_cycle();
        l2_address = 16'h66b0;
        resp_base  = resp_cnt;
        #1;
        chk("dmiss_resp", l2_resp, 0);
        next_cycle(); #1;
        chk("wb_pwrite", pmem_write,   1);
        chk("wb_pread",  pmem_read,    0);
        chk("wb_paddr",  pmem_address, 16'h55b0);
        chk("wb_wdata",  pmem_wdata,   DAT_W1);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #1;
            chk("wb_hold", pmem_write, 1);
        end
        pmem_resp = 1'b1;
        next_cycle();
        pmem_resp = 1'b0;
        #1;
        chk("al2_pread",  pmem_read,    1);
        chk("al2_pwrite", pmem_write,   0);
        chk("al2_paddr",  pmem_address, 16'h66b0);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #1;
            chk("al2_hold", pmem_read, 1);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = DAT_R2;
        #1;
        chk("al2_loadv", way_load_v, 2'b10);
        chk("al2_loadd", way_load_d, 2'b10);
        next_cycle();
        pmem_resp = 1'b0;
        #1;
        chk("al2_resp",  l2_resp,  1);
        chk("al2_rdata", l2_rdata, DAT_R2);
        chk("al2_clean", d_m[1][3], 0);
        next_cycle();
        l2_read = 1'b0;
        @(negedge clk);
        #1;
        chk("dmiss_resp_once", resp_cnt - resp_base, 1);
        chk("no_overlap",      overlap,              0);

        // Reset in the middle of a writeback of dirty way0
        next_cycle();
        l2_read    = 1'b1;
        l2_address = 16'h55b0;
        #1;
        chk("rwb_miss", l2_resp, 0);
        next_cycle(); #1;
        chk("rwb_pwrite", pmem_write,   1);
        chk("rwb_paddr",  pmem_address, 16'h1230);
        chk("rwb_wdata",  pmem_wdata,   DAT_D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pwrite", pmem_write, 0);
        chk("async_pread",  pmem_read,  0);
        chk("async_resp",   l2_resp,    0);
        l2_address = 16'h1230;
        @(posedge clk);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
        end
        #1;
        chk("post_rst_miss",  l2_resp,   0);
        chk("post_rst_v0",    v_m[0][3], 0);
        next_cycle(); #1;
        chk("post_rst_pread",  pmem_read,    1);
        chk("post_rst_pwrite", pmem_write,   0);
        chk("post_rst_paddr",  pmem_address, 16'h1230);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
